// File: rtl/port_sequencer.sv
// N-port request sequencer: fixed/round-robin pick, one-deep registered output tagged with port id.
// Optional starvation aging is enabled by defining PORT_SEQ_AGING_EN.

`ifdef PORT_SEQ_AGING_EN
module port_seq_wait_ctr #(
  parameter int MAX_WAIT = 15,
  localparam int CW = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic ready,
  output logic aged
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !valid || ready) cnt <= '0;
    else if (cnt != CW'(MAX_WAIT)) cnt <= cnt + 1'b1;
  end

  assign aged = (cnt == CW'(MAX_WAIT));
endmodule
`endif

module port_sequencer #(
  parameter int NUM_PORTS = 3,
  parameter int WIDTH     = 8,
  parameter int MAX_WAIT  = 15,
  localparam int PID_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*WIDTH-1:0] port_data,
  input  logic [NUM_PORTS-1:0]       port_valid,
  output logic [NUM_PORTS-1:0]       port_ready,
  input  logic                       rr_mode,
  output logic [WIDTH-1:0]           mem_data,
  output logic                       mem_valid,
  output logic [PID_W-1:0]           mem_pid,
  input  logic                       mem_ready
);
  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("port_sequencer: NUM_PORTS must be 2..8");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("port_sequencer: MAX_WAIT must be 1..255");
  end

  logic [PID_W-1:0]     rr_ptr, sel, nxt_ptr;
  logic [PID_W:0]       rot;
  logic                 found, free, grant;
  logic [NUM_PORTS-1:0] aged;

`ifdef PORT_SEQ_AGING_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wait
    port_seq_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .valid(port_valid[i]),
      .ready(port_ready[i]),
      .aged (aged[i])
    );
  end
`else
  assign aged = '0;
`endif

  assign free  = !mem_valid || mem_ready;
  assign grant = found && free && !rst;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    rot   = '0;
    if (rr_mode) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        rot = {1'b0, rr_ptr} + (PID_W+1)'(k);
        if (rot >= (PID_W+1)'(NUM_PORTS)) rot = rot - (PID_W+1)'(NUM_PORTS);
        if (!found && port_valid[rot[PID_W-1:0]]) begin
          found = 1'b1;
          sel   = rot[PID_W-1:0];
        end
      end
    end else begin
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
        if (port_valid[PID_W'(i)]) begin
          found = 1'b1;
          sel   = PID_W'(i);
        end
      end
    end
    // an aged requester overrides either mode; descending scan leaves the lowest index
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (aged[PID_W'(i)] && port_valid[PID_W'(i)]) begin
        found = 1'b1;
        sel   = PID_W'(i);
      end
    end
  end

  always_comb begin
    port_ready = '0;
    if (grant) port_ready[sel] = 1'b1;
  end

  assign nxt_ptr = (sel == PID_W'(NUM_PORTS-1)) ? '0 : sel + PID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
      mem_pid   <= '0;
      rr_ptr    <= '0;
    end else if (free) begin
      if (found) begin
        mem_valid <= 1'b1;
        mem_data  <= port_data[sel*WIDTH +: WIDTH];
        mem_pid   <= sel;
        rr_ptr    <= nxt_ptr;
      end else begin
        mem_valid <= 1'b0;
      end
    end
  end
endmodule
